// File: rtl/btb_pkg.sv
// Shared encodings and helpers for the branch target buffer.
package btb_pkg;

    // 2-bit direction counter encodings
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Counter value written when a missing entry is allocated
    localparam logic [1:0] ALLOC_BR  = WT;
    localparam logic [1:0] ALLOC_JMP = ST;

    // Saturating step of a direction counter toward the resolved direction
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == ST) ? ST : cnt + 2'd1;
        else
            return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/btb_ram.sv
// 1R1W synchronous RAM, registered read, write-first on address collision.
module btb_ram #(
    parameter int AW = 11,
    parameter int DW = 15
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port plus registered read; a same-address write is forwarded
    always_ff @(posedge CLK) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/btb_predict_param.sv
// Direct-mapped BTB with 2-bit direction counters, redirect mux and perf counters.
module btb_predict_param
    import btb_pkg::*;
#(
    parameter int PC_W  = 13,
    parameter int IDX_W = 11,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [PC_W-1:0]  pcF,
    output logic [PC_W-1:0]  prepc,
    output logic             hit_predict,
    output logic             taken_predict,
    output logic [1:0]       state,
    input  logic             upd_en,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic             upd_jump,
    input  logic [PC_W-1:0]  upd_target,
    input  logic [PC_W-1:0]  pcD,
    input  logic [PC_W-1:0]  nextpcD,
    input  logic             fail_predictD,
    input  logic [PC_W-1:0]  pcE,
    input  logic [PC_W-1:0]  nextpcE,
    input  logic             fail_predictE,
    output logic [PC_W-1:0]  nextpc,
    output logic             fail_predict,
    output logic [CNT_W-1:0] lookups,
    output logic [CNT_W-1:0] mispredicts
);
    localparam int TAG_W   = PC_W - IDX_W;
    localparam int ENTRIES = 1 << IDX_W;
    localparam int DW      = TAG_W + PC_W;

    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][1:0]       cnt_q;
    logic [ENTRIES-1:0][TAG_W-1:0] utag_q;

    logic [IDX_W-1:0] upd_idx, lk_idx;
    logic [TAG_W-1:0] upd_tag, lk_tag, lk_tag_q, ram_tag;
    logic             upd_hit, cnt_we, ram_we, byp, lk_valid_q;
    logic [1:0]       new_cnt, lk_cnt_q;
    logic [DW-1:0]    ram_rdata;
    logic [PC_W-1:0]  ram_tgt;

    // D/E stage PCs are carried for interface compatibility only
    logic unused_pcs;
    assign unused_pcs = ^{pcD, pcE};

    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[PC_W-1:IDX_W];
    assign lk_idx  = pcF[IDX_W-1:0];
    assign lk_tag  = pcF[PC_W-1:IDX_W];

    // The RAM read port belongs to the lookup, so the update side keeps its own tag copy
    assign upd_hit = valid_q[upd_idx] && (utag_q[upd_idx] == upd_tag);

    // Tag and target are rewritten whenever the branch went somewhere; on a hit the tag is unchanged
    assign ram_we = upd_en && (upd_taken || upd_jump);

    // Decode the training action for the resolved branch
    always_comb begin
        cnt_we  = 1'b0;
        new_cnt = cnt_q[upd_idx];
        if (upd_en) begin
            if (upd_hit) begin
                cnt_we  = 1'b1;
                new_cnt = upd_jump ? ST : sat_next(cnt_q[upd_idx], upd_taken);
            end else if (upd_taken || upd_jump) begin
                cnt_we  = 1'b1;
                new_cnt = upd_jump ? ALLOC_JMP : ALLOC_BR;
            end
        end
    end

    // Valid bits and direction counters; reset drops any coincident update
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else if (cnt_we) begin
            valid_q[upd_idx] <= 1'b1;
            cnt_q[upd_idx]   <= new_cnt;
        end
    end

    // Update-side tag copy; a write during reset is harmless since valid is cleared
    always_ff @(posedge CLK) begin
        if (ram_we)
            utag_q[upd_idx] <= upd_tag;
    end

    btb_ram #(.AW(IDX_W), .DW(DW)) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (upd_idx),
        .wdata ({upd_tag, upd_target}),
        .raddr (lk_idx),
        .rdata (ram_rdata)
    );

    assign {ram_tag, ram_tgt} = ram_rdata;

    // Same-index update bypasses into the lookup so the result is write-first
    assign byp = cnt_we && (upd_idx == lk_idx);

    // Register the flop-side half of the lookup alongside the RAM read
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lk_valid_q <= 1'b0;
            lk_cnt_q   <= SNT;
            lk_tag_q   <= '0;
        end else begin
            lk_valid_q <= byp ? 1'b1 : valid_q[lk_idx];
            lk_cnt_q   <= byp ? new_cnt : cnt_q[lk_idx];
            lk_tag_q   <= lk_tag;
        end
    end

    // Outputs are qualified by the registered valid, so reset forces them to zero at once
    assign hit_predict   = lk_valid_q && (ram_tag == lk_tag_q);
    assign state         = hit_predict ? lk_cnt_q : SNT;
    assign taken_predict = hit_predict && lk_cnt_q[1];
    assign prepc         = hit_predict ? ram_tgt : '0;

    // E-stage correction wins over D-stage
    assign nextpc       = fail_predictE ? nextpcE : nextpcD;
    assign fail_predict = fail_predictD | fail_predictE;

    // Performance counters, wrapping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lookups     <= '0;
            mispredicts <= '0;
        end else begin
            lookups     <= lookups + CNT_W'(hit_predict);
            mispredicts <= mispredicts + CNT_W'(fail_predictE);
        end
    end

endmodule

// File: tb/tb_btb_predict_param.sv
// Self-checking bench for btb_predict_param: directed steps then random traffic vs a table model.
module tb_btb_predict_param;
    localparam int PC_W  = 13;
    localparam int IDX_W = 11;
    localparam int CNT_W = 32;
    localparam int N     = 1 << IDX_W;

    logic             CLK = 1'b0;
    logic             RST;
    logic [PC_W-1:0]  pcF, prepc, upd_pc, upd_target, pcD, nextpcD, pcE, nextpcE, nextpc;
    logic             hit_predict, taken_predict, upd_en, upd_taken, upd_jump;
    logic             fail_predictD, fail_predictE, fail_predict;
    logic [1:0]       state;
    logic [CNT_W-1:0] lookups, mispredicts;

    btb_predict_param #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .pcF(pcF), .prepc(prepc), .hit_predict(hit_predict),
        .taken_predict(taken_predict), .state(state), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_jump(upd_jump), .upd_target(upd_target),
        .pcD(pcD), .nextpcD(nextpcD), .fail_predictD(fail_predictD),
        .pcE(pcE), .nextpcE(nextpcE), .fail_predictE(fail_predictE),
        .nextpc(nextpc), .fail_predict(fail_predict),
        .lookups(lookups), .mispredicts(mispredicts)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference table, plain integers
    bit mvalid [N];
    int mtag   [N];
    int mtgt   [N];
    int mcnt   [N];
    int exp_hit, exp_state, exp_tgt;
    longint exp_lookups, exp_misp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mvalid[i] = 1'b0;
            mcnt[i]   = 0;
        end
        exp_hit = 0; exp_state = 0; exp_tgt = 0;
        exp_lookups = 0; exp_misp = 0;
    endtask

    // One clock edge worth of behaviour: train, count, then look up the post-update table
    task automatic model_step();
        int i, t;
        bit h;
        if (upd_en) begin
            i = int'(upd_pc) % N;
            t = int'(upd_pc) / N;
            h = mvalid[i] && (mtag[i] == t);
            if (h) begin
                if (upd_jump) begin
                    mcnt[i] = 3; mtgt[i] = int'(upd_target);
                end else if (upd_taken) begin
                    mcnt[i] = (mcnt[i] < 3) ? mcnt[i] + 1 : 3; mtgt[i] = int'(upd_target);
                end else begin
                    mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
                end
            end else if (upd_taken || upd_jump) begin
                mvalid[i] = 1'b1; mtag[i] = t; mtgt[i] = int'(upd_target);
                mcnt[i] = upd_jump ? 3 : 2;
            end
        end
        exp_lookups += exp_hit;
        exp_misp    += fail_predictE;
        i = int'(pcF) % N;
        t = int'(pcF) / N;
        exp_hit   = (mvalid[i] && mtag[i] == t) ? 1 : 0;
        exp_state = exp_hit ? mcnt[i] : 0;
        exp_tgt   = mtgt[i];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hit"}, 32'(hit_predict), 32'(exp_hit));
        chk({tag, ".state"}, 32'(state), 32'(exp_state));
        chk({tag, ".taken"}, 32'(taken_predict), 32'(exp_hit != 0 && exp_state >= 2));
        if (exp_hit != 0) chk({tag, ".prepc"}, 32'(prepc), 32'(exp_tgt));
        chk({tag, ".lookups"}, lookups, 32'(exp_lookups));
        chk({tag, ".mispred"}, mispredicts, 32'(exp_misp));
        chk({tag, ".nextpc"}, 32'(nextpc), fail_predictE ? 32'(nextpcE) : 32'(nextpcD));
        chk({tag, ".fail"}, 32'(fail_predict), 32'(fail_predictD | fail_predictE));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        upd_en = 0; upd_taken = 0; upd_jump = 0; upd_pc = '0; upd_target = '0;
        fail_predictD = 0; fail_predictE = 0; nextpcD = '0; nextpcE = '0;
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic tk, input logic jp,
                       input logic [PC_W-1:0] tg);
        upd_en = 1; upd_pc = pc; upd_taken = tk; upd_jump = jp; upd_target = tg;
    endtask

    function automatic logic [PC_W-1:0] rnd_pc();
        logic [IDX_W-1:0] pool [4];
        pool[0] = 11'h023; pool[1] = 11'h040; pool[2] = 11'h123; pool[3] = 11'h7FF;
        return {2'($urandom_range(0, 3)), pool[$urandom_range(0, 3)]};
    endfunction

    initial begin
        RST = 1; pcF = '0; pcD = '0; pcE = '0;
        idle();
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.hit", 32'(hit_predict), 0);
        chk("rst.prepc", 32'(prepc), 0);
        RST = 0;

        // 1: empty table misses
        pcF = 13'h0123;
        cycle("t1");
        chk("t1.hit0", 32'(hit_predict), 0);
        chk("t1.lookups0", lookups, 0);

        // 2: allocate a taken branch, then hit; same index other tag misses
        upd(13'h0123, 1, 0, 13'h0200); pcF = 13'h0000;
        cycle("t2a");
        idle(); pcF = 13'h0123;
        cycle("t2b");
        chk("t2.hit", 32'(hit_predict), 1);
        chk("t2.state", 32'(state), 2);
        chk("t2.taken", 32'(taken_predict), 1);
        chk("t2.prepc", 32'(prepc), 32'h0200);
        pcF = 13'h0923;
        cycle("t2c");
        chk("t2.otag", 32'(hit_predict), 0);

        // 3: saturate up, then down
        pcF = 13'h0123;
        repeat (3) begin upd(13'h0123, 1, 0, 13'h0200); cycle("t3up"); end
        chk("t3.sat3", 32'(state), 3);
        repeat (4) begin upd(13'h0123, 0, 0, 13'h0000); cycle("t3dn"); end
        chk("t3.sat0", 32'(state), 0);
        chk("t3.nt", 32'(taken_predict), 0);
        chk("t3.stillhit", 32'(hit_predict), 1);

        // 4: jump allocated and looked up in the same cycle
        upd(13'h0040, 0, 1, 13'h1000); pcF = 13'h0040;
        cycle("t4");
        chk("t4.hit", 32'(hit_predict), 1);
        chk("t4.state", 32'(state), 3);
        chk("t4.prepc", 32'(prepc), 32'h1000);
        idle();

        // 5: redirect priority and mispredict counting
        fail_predictD = 1; nextpcD = 13'h0010; fail_predictE = 1; nextpcE = 13'h0020;
        #1;
        chk("t5.nextpcE", 32'(nextpc), 32'h0020);
        chk("t5.failDE", 32'(fail_predict), 1);
        cycle("t5a");
        fail_predictE = 0;
        #1;
        chk("t5.nextpcD", 32'(nextpc), 32'h0010);
        cycle("t5b");
        idle();
        cycle("t5c");

        // 6: reset mid-stream with a coincident update
        upd(13'h0555, 0, 1, 13'h0777); pcF = 13'h0123;
        cycle("t6pre");
        upd(13'h0666, 1, 0, 13'h0abc); pcF = 13'h0666;
        RST = 1;
        #1;
        chk("t6.hit", 32'(hit_predict), 0);
        chk("t6.state", 32'(state), 0);
        chk("t6.taken", 32'(taken_predict), 0);
        chk("t6.prepc", 32'(prepc), 0);
        chk("t6.lookups", lookups, 0);
        chk("t6.mispred", mispredicts, 0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 0;
        idle();
        pcF = 13'h0666;
        cycle("t6miss_upd");
        pcF = 13'h0123;
        cycle("t6miss_old");
        pcF = 13'h0040;
        cycle("t6miss_jmp");

        // Random traffic on a few colliding indices
        for (int n = 0; n < 400; n++) begin
            idle();
            pcF = rnd_pc();
            if ($urandom_range(0, 3) != 0)
                upd(rnd_pc(), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                    13'($urandom));
            fail_predictD = 1'($urandom_range(0, 1));
            fail_predictE = 1'($urandom_range(0, 1));
            nextpcD = 13'($urandom);
            nextpcE = 13'($urandom);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
